// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the pattern serializer and its consumers:
// FSM state encoding and the default pattern width.
package pattern_serializer_pkg;

  localparam int DEFAULT_WIDTH = 48;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/pattern_serializer.sv
// Pattern serializer: captures a WIDTH-bit pattern plus mode bit on load and
// emits it MSB-first on a registered serial line X, one bit per step cycle.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic             mode,
  input  logic             step,
  input  logic             abort,
  output logic             X,
  output logic             M,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bits_left
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               x_q, x_d;
  logic               m_q, m_d;
  logic               x_valid_q, x_valid_d;
  logic [CNT_W-1:0]   bits_left_q, bits_left_d;

  // State register: synchronous active-low reset clears every flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      x_q         <= 1'b0;
      m_q         <= 1'b0;
      x_valid_q   <= 1'b0;
      bits_left_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      x_q         <= x_d;
      m_q         <= m_d;
      x_valid_q   <= x_valid_d;
      bits_left_q <= bits_left_d;
    end
  end

  // Next-state and datapath: capture on load, shift one bit per step,
  // abort wins over step and drops back to idle without a done pulse.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    x_d         = x_q;
    m_d         = m_q;
    x_valid_d   = 1'b0;
    bits_left_d = bits_left_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shreg_d     = pattern;
          m_d         = mode;
          bits_left_d = CNT_W'(WIDTH);
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          x_d         = 1'b0;
          bits_left_d = '0;
          state_d     = S_IDLE;
        end else if (step) begin
          x_d         = shreg_q[WIDTH-1];
          shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
          bits_left_d = bits_left_q - CNT_W'(1);
          x_valid_d   = 1'b1;
          if (bits_left_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Single-cycle completion marker; load here is dropped, not queued.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy = (state_q == S_SHIFT);
    done = (state_q == S_DONE);
  end

  assign X         = x_q;
  assign M         = m_q;
  assign x_valid   = x_valid_q;
  assign bits_left = bits_left_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: a short vector table for the
// basic cycle-by-cycle behaviour, then hand-written multi-cycle sequences.
// Expected serial bits are queued when a load is accepted and popped on
// every x_valid pulse.
module tb_pattern_serializer;

  localparam int WIDTH = 48;
  localparam int CNT_W = 6;

  localparam logic [WIDTH-1:0] P_MAIN = 48'h56B1AD6E965B;
  localparam logic [WIDTH-1:0] P_TBL  = 48'hC00000000001;
  localparam logic [WIDTH-1:0] P_ONES = 48'hFFFFFFFFFFFF;
  localparam logic [WIDTH-1:0] P_ONE  = 48'h000000000001;

  logic             clk = 1'b0;
  logic             reset, load, mode, step, abort;
  logic [WIDTH-1:0] pattern;
  logic             X, M, x_valid, busy, done;
  logic [CNT_W-1:0] bits_left;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int done_cnt = 0;
  int xv_cnt   = 0;
  logic exp_q[$];

  typedef struct {
    logic             load;
    logic             mode;
    logic             step;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic             e_busy;
    logic             e_done;
    logic             e_xv;
    logic             e_x;
    logic             e_m;
    logic [CNT_W-1:0] e_bl;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  pattern_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .pattern   (pattern),
    .mode      (mode),
    .step      (step),
    .abort     (abort),
    .X         (X),
    .M         (M),
    .x_valid   (x_valid),
    .busy      (busy),
    .done      (done),
    .bits_left (bits_left)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_bits(input logic [WIDTH-1:0] p);
    for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(p[i]);
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (x_valid === 1'b1) begin
      xv_cnt++;
      if (exp_q.size() == 0) chk("x_valid_unexpected", 64'(x_valid), 64'd0);
      else chk("x_bit", 64'(X), 64'(exp_q.pop_front()));
    end
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic idle_inputs();
    load = 1'b0; step = 1'b0; abort = 1'b0; mode = 1'b0; pattern = '0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] p, input logic md);
    load = 1'b1; pattern = p; mode = md;
    push_bits(p);
    tick();
    load = 1'b0;
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_bits_left", 64'(bits_left), 64'(WIDTH));
    chk("load_M", 64'(M), 64'(md));
  endtask

  initial begin
    // Table: starts in IDLE with X=0, M=0 right after reset.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, '0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, P_TBL,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd48};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd48};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, '0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd47};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd47};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, '0,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'd46};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, '0,     1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 6'd45};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, '0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, '0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0};

    idle_inputs();
    reset = 1'b0;
    tick();
    chk("rst_X", 64'(X), 64'd0);
    chk("rst_M", 64'(M), 64'd0);
    chk("rst_x_valid", 64'(x_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bits_left", 64'(bits_left), 64'd0);
    reset = 1'b1;

    // Table-driven basic vectors.
    for (int v = 0; v < 9; v++) begin
      load = tbl[v].load; mode = tbl[v].mode; step = tbl[v].step;
      abort = tbl[v].abort; pattern = tbl[v].pattern;
      if (tbl[v].load) push_bits(tbl[v].pattern);
      tick();
      if (tbl[v].abort && tbl[v].e_busy == 1'b0) exp_q.delete();
      chk($sformatf("tbl%0d_busy", v), 64'(busy), 64'(tbl[v].e_busy));
      chk($sformatf("tbl%0d_done", v), 64'(done), 64'(tbl[v].e_done));
      chk($sformatf("tbl%0d_xv", v), 64'(x_valid), 64'(tbl[v].e_xv));
      chk($sformatf("tbl%0d_X", v), 64'(X), 64'(tbl[v].e_x));
      chk($sformatf("tbl%0d_M", v), 64'(M), 64'(tbl[v].e_m));
      chk($sformatf("tbl%0d_bl", v), 64'(bits_left), 64'(tbl[v].e_bl));
    end
    idle_inputs();

    // Full pattern with step tied high.
    xv_cnt = 0; done_cnt = 0;
    step = 1'b1;
    do_load(P_MAIN, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      if (done === 1'b1) chk("full_done_early", 64'(done), 64'd0);
      tick();
      chk("full_bits_left", 64'(bits_left), 64'(WIDTH - 1 - i));
    end
    chk("full_done", 64'(done), 64'd1);
    chk("full_busy_fall", 64'(busy), 64'd0);
    tick();
    chk("full_done_one_cycle", 64'(done), 64'd0);
    chk("full_X_hold", 64'(X), 64'd1);
    chk("full_xv_count", 64'(xv_cnt), 64'(WIDTH));
    chk("full_done_count", 64'(done_cnt), 64'd1);
    chk("full_queue_empty", 64'(exp_q.size()), 64'd0);

    // Gapped stepping: one step every third cycle.
    xv_cnt = 0; done_cnt = 0;
    step = 1'b0;
    do_load(P_MAIN, 1'b0);
    begin
      int exp_bl;
      exp_bl = WIDTH;
      for (int c = 0; c < 3 * WIDTH; c++) begin
        step = (c % 3 == 2);
        if (step) exp_bl--;
        tick();
        chk("gap_bits_left", 64'(bits_left), 64'(exp_bl));
        chk("gap_xv", 64'(x_valid), 64'(step));
      end
    end
    step = 1'b0;
    chk("gap_done", 64'(done), 64'd1);
    chk("gap_xv_count", 64'(xv_cnt), 64'(WIDTH));
    tick();

    // Abort after 10 bits, then restart from the top.
    done_cnt = 0;
    step = 1'b1;
    do_load(P_MAIN, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_pre_bl", 64'(bits_left), 64'd38);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_X", 64'(X), 64'd0);
    chk("abort_bl", 64'(bits_left), 64'd0);
    chk("abort_M_hold", 64'(M), 64'd1);
    chk("abort_queue_left", 64'(exp_q.size()), 64'd38);
    exp_q.delete();
    tick();
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    do_load(P_MAIN, 1'b0);

    // Ignored load during SHIFT: stream, M and done timing unchanged.
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= 5 && i < 8) begin
        load = 1'b1; pattern = P_ONES; mode = 1'b1;
      end else begin
        load = 1'b0; pattern = '0; mode = 1'b0;
      end
      tick();
      chk("ign_M", 64'(M), 64'd0);
      if (i < WIDTH - 1) chk("ign_no_early_done", 64'(done), 64'd0);
    end
    load = 1'b0;
    chk("ign_done_on_time", 64'(done), 64'd1);
    chk("ign_queue_empty", 64'(exp_q.size()), 64'd0);
    tick();

    // Reset in the middle of a transfer.
    do_load(P_MAIN, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    chk("mrst_X", 64'(X), 64'd0);
    chk("mrst_M", 64'(M), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_bl", 64'(bits_left), 64'd0);
    chk("mrst_xv", 64'(x_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_stay_idle_busy", 64'(busy), 64'd0);
      chk("mrst_stay_idle_xv", 64'(x_valid), 64'd0);
      chk("mrst_stay_idle_bl", 64'(bits_left), 64'd0);
    end

    // Mode capture and chaining; load during DONE is dropped.
    do_load(P_ONE, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      chk("chain_M", 64'(M), 64'd1);
      chk("chain_X", 64'(X), 64'((i == WIDTH - 1) ? 1 : 0));
    end
    chk("chain_done", 64'(done), 64'd1);
    load = 1'b1; pattern = P_MAIN; mode = 1'b0;
    tick();
    load = 1'b0;
    chk("chain_done_load_dropped", 64'(busy), 64'd0);
    chk("chain_M_hold", 64'(M), 64'd1);
    do_load(P_MAIN, 1'b0);
    for (int i = 0; i < WIDTH; i++) tick();
    chk("chain2_done", 64'(done), 64'd1);
    chk("chain2_queue_empty", 64'(exp_q.size()), 64'd0);
    step = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
